// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: STAGES-deep segmented adder/subtractor with valid/ready and whole-pipe stall.
// Optional ADD_SUB_SATURATE_EN clamps S to the signed range on overflow.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int SEG = WIDTH / STAGES;
  logic              en;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  pa [STAGES];
  logic [WIDTH-1:0]  pb [STAGES];
  logic [WIDTH-1:0]  ps [STAGES];
  logic              pc [STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v[STAGES-1];
  assign pa[0]     = a;
  assign pb[0]     = sub ? ~b : b;
  assign ps[0]     = '0;
  assign pc[0]     = sub | ci;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else if (en) v <= STAGES'({v, in_valid});
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic [SEG:0]     t;
    logic [WIDTH-1:0] ns;
    assign t = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]} + (SEG+1)'(pc[k]);
    always_comb begin
      ns = ps[k];
      ns[k*SEG +: SEG] = t[SEG-1:0];
    end
    if (k < STAGES - 1) begin : m
      logic [WIDTH-1:0] ra, rb, rs;
      logic             rc;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ra <= '0;
          rb <= '0;
          rs <= '0;
          rc <= 1'b0;
        end else if (en) begin
          ra <= pa[k];
          rb <= pb[k];
          rs <= ns;
          rc <= t[SEG];
        end
      assign pa[k+1] = ra;
      assign pb[k+1] = rb;
      assign ps[k+1] = rs;
      assign pc[k+1] = rc;
    end else begin : o
      logic             cm, ov;
      logic [WIDTH-1:0] sf;
      // carry into the MSB recovered from the MSB sum bit and its operand bits
      assign cm = ns[WIDTH-1] ^ pa[k][WIDTH-1] ^ pb[k][WIDTH-1];
      assign ov = cm ^ t[SEG];
`ifdef ADD_SUB_SATURATE_EN
      assign sf = ov ? {pa[k][WIDTH-1], {(WIDTH-1){~pa[k][WIDTH-1]}}} : ns;
`else
      assign sf = ns;
`endif
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s    <= '0;
          co   <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (en) begin
          s    <= sf;
          co   <= t[SEG];
          ovf  <= ov;
          zero <= ~|sf;
        end
    end
  end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: random + directed checks of pipelined_add_sub against an arithmetic model.
module tb_pipelined_add_sub;
  localparam int W  = 32;
  localparam int ST = 4;
  typedef struct {logic [W-1:0] s; logic co, ovf, zero;} res_t;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, ci = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, co, ovf, zero;
  logic [W-1:0] a = '0, b = '0, s, s_prev;
  logic         stalled = 1'b0, done = 1'b0;
  int           tests = 0, fails = 0, nout = 0;
  res_t         q[$];
  res_t         e;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co),
    .ovf(ovf), .zero(zero)
  );

  function automatic res_t model(input logic [W-1:0] x, y, input logic c, m);
    logic [W-1:0] yy;
    logic [W:0]   sum;
    res_t         r;
    yy    = m ? ~y : y;
    sum   = {1'b0, x} + {1'b0, yy} + (W+1)'(m ? 1'b1 : c);
    r.s   = sum[W-1:0];
    r.co  = sum[W];
    r.ovf = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
`ifdef ADD_SUB_SATURATE_EN
    if (r.ovf) r.s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.s == '0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stalled) chk("stall_hold", s, s_prev);
      if (out_valid && out_ready) begin
        nout++;
        if (q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("s", s, e.s);
          chk("co", co, e.co);
          chk("ovf", ovf, e.ovf);
          chk("zero", zero, e.zero);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, ci, sub));
      stalled = out_valid && !out_ready;
      s_prev  = s;
    end
  end

  task automatic send(input logic [W-1:0] x, y, input logic c, m);
    a = x; b = y; ci = c; sub = m; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] x, y, input logic c, m,
                     input logic [W-1:0] es, input logic eco, eovf, ez);
    int cnt;
    send(x, y, c, m);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 20);
    chk({nm, "_lat"}, cnt, ST);
    chk({nm, "_s"}, s, es);
    chk({nm, "_co"}, co, eco);
    chk({nm, "_ovf"}, ovf, eovf);
    chk({nm, "_zero"}, zero, ez);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {co, ovf, zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    lit("wrap_zero", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    lit("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    lit("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
`ifdef ADD_SUB_SATURATE_EN
    lit("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    lit("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    lit("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    lit("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
    lit("seg_carry", 32'h00FF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    lit("ci_carry", 32'h0000_00FF, 32'd0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    base = nout;
    fork
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      begin
        for (int i = 0; i < 40 && nout < base + 2; i++) begin @(posedge clk); #1; end
        chk("bp_reached", nout - base, 2);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", nout - base, 8);

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          send(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = ($urandom_range(3) != 0); end
        out_ready = 1'b1;
      end
    join
    drain();

    base = nout;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    chk("no_stale_count", nout - base, 0);
    lit("post_rst", 32'd10, 32'd20, 1'b1, 1'b0, 32'd31, 1'b0, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
